line_req_arbiter: RTL and testbench

//  Shares one 128-bit line-request port (write: start/addr/data/mask -> finish_wresp; read: start/addr -> data/valid -> finish_mrd)

---
 rtl/line_req_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_line_req_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_req_arbiter.sv
// Purpose : shares one 128-bit line-request port between the uart monitor and the dcache fill/flush requesters.
// Latency : request pulse -> downstream start pulse = 3 cycles from idle; responses routed combinationally.
// Backpres: one transaction outstanding; a pulse into an occupied slot is dropped and sets sticky arb_err_o.
//
// Ports: clk_i/rst_n_i; per requester (uart_*, dc_*) write pulse + addr/data/mask, read pulse + addr,
//        finish_wresp_o, broadcast rdat data/mask, owner-only rdat valid and finish_mrd;
//        m_* downstream request outputs and response inputs; arb_err_o sticky error.
// Optional: define LRA_WDT_EN to abort a stalled WAIT_* after WDT cycles with a synthetic finish pulse.
module line_req_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 128,
    parameter int WDT = 255
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            uart_wstart_rq_i,
    input  logic [AW-1:0]   uart_win_addr_i,
    input  logic [DW-1:0]   uart_in_wdata_i,
    input  logic [DW/8-1:0] uart_in_mask_i,
    output logic            uart_finish_wresp_o,
    input  logic            uart_rstart_rq_i,
    input  logic [AW-1:0]   uart_rin_addr_i,
    output logic [DW-1:0]   uart_rdat_m_data_o,
    output logic [DW/8-1:0] uart_rdat_m_mask_o,
    output logic            uart_rdat_m_valid_o,
    output logic            uart_finish_mrd_o,
    input  logic            dc_wstart_rq_i,
    input  logic [AW-1:0]   dc_win_addr_i,
    input  logic [DW-1:0]   dc_in_wdata_i,
    input  logic [DW/8-1:0] dc_in_mask_i,
    output logic            dc_finish_wresp_o,
    input  logic            dc_rstart_rq_i,
    input  logic [AW-1:0]   dc_rin_addr_i,
    output logic [DW-1:0]   dc_rdat_m_data_o,
    output logic [DW/8-1:0] dc_rdat_m_mask_o,
    output logic            dc_rdat_m_valid_o,
    output logic            dc_finish_mrd_o,
    output logic            m_wstart_rq_o,
    output logic [AW-1:0]   m_win_addr_o,
    output logic [DW-1:0]   m_in_wdata_o,
    output logic [DW/8-1:0] m_in_mask_o,
    input  logic            m_finish_wresp_i,
    output logic            m_rstart_rq_o,
    output logic [AW-1:0]   m_rin_addr_o,
    input  logic [DW-1:0]   m_rdat_m_data_i,
    input  logic [DW/8-1:0] m_rdat_m_mask_i,
    input  logic            m_rdat_m_valid_i,
    input  logic            m_finish_mrd_i,
    output logic            arb_err_o
);
    localparam int MW = DW / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_W, WAIT_R} state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;   // 1 = dc, 0 = uart
    logic   wr_q, wr_d;         // 1 = write transaction
    logic   rr_q, rr_d;         // preferred requester when both pend
    logic   err_q, err_d;

    // request slots
    logic          uw_vld_q, uw_vld_d, ur_vld_q, ur_vld_d;
    logic          dw_vld_q, dw_vld_d, dr_vld_q, dr_vld_d;
    logic [AW-1:0] uw_addr_q, ur_addr_q, dw_addr_q, dr_addr_q;
    logic [DW-1:0] uw_data_q, dw_data_q;
    logic [MW-1:0] uw_mask_q, dw_mask_q;

    // downstream request registers
    logic          m_wstart_q, m_rstart_q;
    logic [AW-1:0] m_waddr_q, m_raddr_q;
    logic [DW-1:0] m_wdata_q;
    logic [MW-1:0] m_wmask_q;

    logic clr_uw, clr_ur, clr_dw, clr_dr;
    logic ld_uw, ld_ur, ld_dw, ld_dr;
    logic drop;
    logic in_ww, in_wr, wdt_hit;
    logic w_fin, r_fin, r_vld;

    assign in_ww = (state_q == WAIT_W);
    assign in_wr = (state_q == WAIT_R);

`ifdef LRA_WDT_EN
    localparam int CW = $clog2(WDT + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    assign wdt_hit = (in_ww || in_wr) && (cnt_q == CW'(WDT));

    // Zero on the ISSUE->WAIT edge, so the count equals cycles spent waiting.
    always_comb begin
        cnt_d = '0;
        if (in_ww || in_wr) cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`else
    // Never true for a non-negative limit; keeps WDT referenced without the watchdog.
    assign wdt_hit = (WDT < 0);
`endif

    // Slot that is being issued this cycle; a same-cycle pulse reloads it.
    assign clr_uw = (state_q == ISSUE) && !owner_q &&  wr_q;
    assign clr_ur = (state_q == ISSUE) && !owner_q && !wr_q;
    assign clr_dw = (state_q == ISSUE) &&  owner_q &&  wr_q;
    assign clr_dr = (state_q == ISSUE) &&  owner_q && !wr_q;

    assign ld_uw = uart_wstart_rq_i && (!uw_vld_q || clr_uw);
    assign ld_ur = uart_rstart_rq_i && (!ur_vld_q || clr_ur);
    assign ld_dw = dc_wstart_rq_i   && (!dw_vld_q || clr_dw);
    assign ld_dr = dc_rstart_rq_i   && (!dr_vld_q || clr_dr);

    assign drop = (uart_wstart_rq_i && !ld_uw) || (uart_rstart_rq_i && !ld_ur) ||
                  (dc_wstart_rq_i   && !ld_dw) || (dc_rstart_rq_i   && !ld_dr);

    always_comb begin
        uw_vld_d = ld_uw || (uw_vld_q && !clr_uw);
        ur_vld_d = ld_ur || (ur_vld_q && !clr_ur);
        dw_vld_d = ld_dw || (dw_vld_q && !clr_dw);
        dr_vld_d = ld_dr || (dr_vld_q && !clr_dr);
        err_d    = err_q || drop || wdt_hit;
    end

    // Arbitration / transaction FSM
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        rr_d    = rr_q;
        unique case (state_q)
            IDLE: begin
                if (uw_vld_q || ur_vld_q || dw_vld_q || dr_vld_q) begin
                    if ((uw_vld_q || ur_vld_q) && (dw_vld_q || dr_vld_q)) owner_d = rr_q;
                    else                                                   owner_d = dw_vld_q || dr_vld_q;
                    wr_d    = owner_d ? dw_vld_q : uw_vld_q;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rr_d    = !owner_q;
                state_d = wr_q ? WAIT_W : WAIT_R;
            end
            WAIT_W: if (m_finish_wresp_i || wdt_hit) state_d = IDLE;
            WAIT_R: if (m_finish_mrd_i   || wdt_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            wr_q       <= 1'b0;
            rr_q       <= 1'b1;
            err_q      <= 1'b0;
            uw_vld_q   <= 1'b0;
            ur_vld_q   <= 1'b0;
            dw_vld_q   <= 1'b0;
            dr_vld_q   <= 1'b0;
            uw_addr_q  <= '0;
            ur_addr_q  <= '0;
            dw_addr_q  <= '0;
            dr_addr_q  <= '0;
            uw_data_q  <= '0;
            dw_data_q  <= '0;
            uw_mask_q  <= '0;
            dw_mask_q  <= '0;
            m_wstart_q <= 1'b0;
            m_rstart_q <= 1'b0;
            m_waddr_q  <= '0;
            m_raddr_q  <= '0;
            m_wdata_q  <= '0;
            m_wmask_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            wr_q     <= wr_d;
            rr_q     <= rr_d;
            err_q    <= err_d;
            uw_vld_q <= uw_vld_d;
            ur_vld_q <= ur_vld_d;
            dw_vld_q <= dw_vld_d;
            dr_vld_q <= dr_vld_d;
            if (ld_uw) begin
                uw_addr_q <= uart_win_addr_i;
                uw_data_q <= uart_in_wdata_i;
                uw_mask_q <= uart_in_mask_i;
            end
            if (ld_ur) ur_addr_q <= uart_rin_addr_i;
            if (ld_dw) begin
                dw_addr_q <= dc_win_addr_i;
                dw_data_q <= dc_in_wdata_i;
                dw_mask_q <= dc_in_mask_i;
            end
            if (ld_dr) dr_addr_q <= dc_rin_addr_i;
            m_wstart_q <= (state_q == ISSUE) &&  wr_q;
            m_rstart_q <= (state_q == ISSUE) && !wr_q;
            if ((state_q == ISSUE) && wr_q) begin
                m_waddr_q <= owner_q ? dw_addr_q : uw_addr_q;
                m_wdata_q <= owner_q ? dw_data_q : uw_data_q;
                m_wmask_q <= owner_q ? dw_mask_q : uw_mask_q;
            end
            if ((state_q == ISSUE) && !wr_q) m_raddr_q <= owner_q ? dr_addr_q : ur_addr_q;
        end
    end

    // Response routing: only while waiting, only to the owner.
    assign w_fin = in_ww && (m_finish_wresp_i || wdt_hit);
    assign r_fin = in_wr && (m_finish_mrd_i   || wdt_hit);
    assign r_vld = in_wr && m_rdat_m_valid_i && !wdt_hit;

    assign uart_finish_wresp_o = w_fin && !owner_q;
    assign dc_finish_wresp_o   = w_fin &&  owner_q;
    assign uart_finish_mrd_o   = r_fin && !owner_q;
    assign dc_finish_mrd_o     = r_fin &&  owner_q;
    assign uart_rdat_m_valid_o = r_vld && !owner_q;
    assign dc_rdat_m_valid_o   = r_vld &&  owner_q;
    assign uart_rdat_m_data_o  = m_rdat_m_data_i;
    assign uart_rdat_m_mask_o  = m_rdat_m_mask_i;
    assign dc_rdat_m_data_o    = m_rdat_m_data_i;
    assign dc_rdat_m_mask_o    = m_rdat_m_mask_i;

    assign m_wstart_rq_o = m_wstart_q;
    assign m_rstart_rq_o = m_rstart_q;
    assign m_win_addr_o  = m_waddr_q;
    assign m_in_wdata_o  = m_wdata_q;
    assign m_in_mask_o   = m_wmask_q;
    assign m_rin_addr_o  = m_raddr_q;
    assign arb_err_o     = err_q;

endmodule

// File: tb/tb_line_req_arbiter.sv
// Directed bench for line_req_arbiter: each task drives one scenario and checks outputs against hand-derived values.
// Inputs change 2ns after the rising edge; outputs are sampled 1ns after a change, away from the edge.
// Define LRA_WDT_EN to also exercise the watchdog abort path (WDT = 16).
module tb_line_req_arbiter;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int MW = DW / 8;

    logic clk, rst_n;
    logic          uart_wstart_rq, uart_rstart_rq, dc_wstart_rq, dc_rstart_rq;
    logic [AW-1:0] uart_win_addr, uart_rin_addr, dc_win_addr, dc_rin_addr;
    logic [DW-1:0] uart_in_wdata, dc_in_wdata;
    logic [MW-1:0] uart_in_mask, dc_in_mask;
    logic          uart_finish_wresp, uart_rdat_m_valid, uart_finish_mrd;
    logic          dc_finish_wresp, dc_rdat_m_valid, dc_finish_mrd;
    logic [DW-1:0] uart_rdat_m_data, dc_rdat_m_data;
    logic [MW-1:0] uart_rdat_m_mask, dc_rdat_m_mask;
    logic          m_wstart_rq, m_rstart_rq, m_finish_wresp, m_rdat_m_valid, m_finish_mrd;
    logic [AW-1:0] m_win_addr, m_rin_addr;
    logic [DW-1:0] m_in_wdata, m_rdat_m_data;
    logic [MW-1:0] m_in_mask, m_rdat_m_mask;
    logic          arb_err;

    int n_checks = 0;
    int n_fail   = 0;

    line_req_arbiter #(.AW(AW), .DW(DW), .WDT(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .uart_wstart_rq_i(uart_wstart_rq), .uart_win_addr_i(uart_win_addr),
        .uart_in_wdata_i(uart_in_wdata), .uart_in_mask_i(uart_in_mask),
        .uart_finish_wresp_o(uart_finish_wresp),
        .uart_rstart_rq_i(uart_rstart_rq), .uart_rin_addr_i(uart_rin_addr),
        .uart_rdat_m_data_o(uart_rdat_m_data), .uart_rdat_m_mask_o(uart_rdat_m_mask),
        .uart_rdat_m_valid_o(uart_rdat_m_valid), .uart_finish_mrd_o(uart_finish_mrd),
        .dc_wstart_rq_i(dc_wstart_rq), .dc_win_addr_i(dc_win_addr),
        .dc_in_wdata_i(dc_in_wdata), .dc_in_mask_i(dc_in_mask),
        .dc_finish_wresp_o(dc_finish_wresp),
        .dc_rstart_rq_i(dc_rstart_rq), .dc_rin_addr_i(dc_rin_addr),
        .dc_rdat_m_data_o(dc_rdat_m_data), .dc_rdat_m_mask_o(dc_rdat_m_mask),
        .dc_rdat_m_valid_o(dc_rdat_m_valid), .dc_finish_mrd_o(dc_finish_mrd),
        .m_wstart_rq_o(m_wstart_rq), .m_win_addr_o(m_win_addr),
        .m_in_wdata_o(m_in_wdata), .m_in_mask_o(m_in_mask),
        .m_finish_wresp_i(m_finish_wresp),
        .m_rstart_rq_o(m_rstart_rq), .m_rin_addr_o(m_rin_addr),
        .m_rdat_m_data_i(m_rdat_m_data), .m_rdat_m_mask_i(m_rdat_m_mask),
        .m_rdat_m_valid_i(m_rdat_m_valid), .m_finish_mrd_i(m_finish_mrd),
        .arb_err_o(arb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        uart_wstart_rq = 0; uart_rstart_rq = 0; dc_wstart_rq = 0; dc_rstart_rq = 0;
        uart_win_addr = '0; uart_rin_addr = '0; dc_win_addr = '0; dc_rin_addr = '0;
        uart_in_wdata = '0; dc_in_wdata = '0; uart_in_mask = '0; dc_in_mask = '0;
        m_finish_wresp = 0; m_rdat_m_valid = 0; m_finish_mrd = 0;
        m_rdat_m_data = '0; m_rdat_m_mask = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({m_wstart_rq, m_rstart_rq, arb_err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 000", {m_wstart_rq, m_rstart_rq, arb_err});
        end
        n_checks++;
        if ({m_win_addr, m_rin_addr} !== '0 || m_in_wdata !== '0 || m_in_mask !== '0) begin
            n_fail++; $display("FAIL reset_payload: got addr %h/%h want 0", m_win_addr, m_rin_addr);
        end
        n_checks++;
        if ({uart_finish_wresp, uart_rdat_m_valid, uart_finish_mrd, dc_finish_wresp, dc_rdat_m_valid, dc_finish_mrd} !== 6'b0) begin
            n_fail++; $display("FAIL reset_resp: got nonzero requester response, want 0");
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_basic();
        logic [DW-1:0] d;
        d = {16{8'hA5}};
        uart_wstart_rq = 1; uart_win_addr = 32'h100; uart_in_wdata = d; uart_in_mask = 16'hFFFF;
        tick();
        uart_wstart_rq = 0; uart_win_addr = '0; uart_in_wdata = '0; uart_in_mask = '0;
        tick(); #1;
        n_checks++;
        if (m_wstart_rq !== 1'b0) begin n_fail++; $display("FAIL wr_early: got %b want 0", m_wstart_rq); end
        tick(); #1;
        n_checks++;
        if (m_wstart_rq !== 1'b1) begin n_fail++; $display("FAIL wr_start: got %b want 1", m_wstart_rq); end
        n_checks++;
        if (m_win_addr !== 32'h100 || m_in_wdata !== d || m_in_mask !== 16'hFFFF) begin
            n_fail++; $display("FAIL wr_payload: got %h %h %h want 100 a5.. ffff", m_win_addr, m_in_wdata, m_in_mask);
        end
        tick(); #1;
        n_checks++;
        if (m_wstart_rq !== 1'b0 || m_win_addr !== 32'h100) begin
            n_fail++; $display("FAIL wr_pulse_hold: got start %b addr %h want 0 100", m_wstart_rq, m_win_addr);
        end
        n_checks++;
        if (uart_finish_wresp !== 1'b0) begin n_fail++; $display("FAIL wr_no_early_fin: got %b want 0", uart_finish_wresp); end
        m_finish_wresp = 1; #1;
        n_checks++;
        if (uart_finish_wresp !== 1'b1 || dc_finish_wresp !== 1'b0) begin
            n_fail++; $display("FAIL wr_finish: got uart %b dc %b want 1 0", uart_finish_wresp, dc_finish_wresp);
        end
        tick();
        m_finish_wresp = 0; #1;
        n_checks++;
        if (uart_finish_wresp !== 1'b0) begin n_fail++; $display("FAIL wr_finish_end: got %b want 0", uart_finish_wresp); end
    endtask

    task automatic test_read_rr();
        apply_reset();
        dc_rstart_rq = 1; dc_rin_addr = 32'h200;
        uart_rstart_rq = 1; uart_rin_addr = 32'h300;
        tick();
        idle_inputs();
        tick(); tick(); #1;
        n_checks++;
        if (m_rstart_rq !== 1'b1 || m_rin_addr !== 32'h200) begin
            n_fail++; $display("FAIL rr_first: got start %b addr %h want 1 200", m_rstart_rq, m_rin_addr);
        end
        tick();
        m_rdat_m_valid = 1; m_rdat_m_data = {4{32'hDEADBEEF}}; m_rdat_m_mask = 16'h0F0F; #1;
        n_checks++;
        if (dc_rdat_m_valid !== 1'b1 || uart_rdat_m_valid !== 1'b0) begin
            n_fail++; $display("FAIL rr_valid_dc: got dc %b uart %b want 1 0", dc_rdat_m_valid, uart_rdat_m_valid);
        end
        n_checks++;
        if (uart_rdat_m_data !== {4{32'hDEADBEEF}} || dc_rdat_m_mask !== 16'h0F0F) begin
            n_fail++; $display("FAIL rr_broadcast: got %h %h want deadbeef.. 0f0f", uart_rdat_m_data, dc_rdat_m_mask);
        end
        m_rdat_m_valid = 0; m_finish_mrd = 1; #1;
        n_checks++;
        if (dc_finish_mrd !== 1'b1 || uart_finish_mrd !== 1'b0) begin
            n_fail++; $display("FAIL rr_fin_dc: got dc %b uart %b want 1 0", dc_finish_mrd, uart_finish_mrd);
        end
        tick();
        m_finish_mrd = 0;
        tick(); tick(); #1;
        n_checks++;
        if (m_rstart_rq !== 1'b1 || m_rin_addr !== 32'h300) begin
            n_fail++; $display("FAIL rr_second: got start %b addr %h want 1 300", m_rstart_rq, m_rin_addr);
        end
        tick();
        m_rdat_m_valid = 1; #1;
        n_checks++;
        if (uart_rdat_m_valid !== 1'b1 || dc_rdat_m_valid !== 1'b0) begin
            n_fail++; $display("FAIL rr_valid_uart: got uart %b dc %b want 1 0", uart_rdat_m_valid, dc_rdat_m_valid);
        end
        m_rdat_m_valid = 0; m_finish_mrd = 1; #1;
        n_checks++;
        if (uart_finish_mrd !== 1'b1 || dc_finish_mrd !== 1'b0) begin
            n_fail++; $display("FAIL rr_fin_uart: got uart %b dc %b want 1 0", uart_finish_mrd, dc_finish_mrd);
        end
        tick();
        m_finish_mrd = 0;
    endtask

    task automatic test_w_before_r();
        apply_reset();
        dc_wstart_rq = 1; dc_win_addr = 32'h400; dc_in_wdata = {8{16'h1234}}; dc_in_mask = 16'h00FF;
        dc_rstart_rq = 1; dc_rin_addr = 32'h500;
        tick();
        idle_inputs();
        tick(); tick(); #1;
        n_checks++;
        if (m_wstart_rq !== 1'b1 || m_rstart_rq !== 1'b0 || m_win_addr !== 32'h400 || m_in_mask !== 16'h00FF) begin
            n_fail++; $display("FAIL wr_first: got w %b r %b addr %h mask %h want 1 0 400 00ff", m_wstart_rq, m_rstart_rq, m_win_addr, m_in_mask);
        end
        tick(); tick(); tick(); #1;
        n_checks++;
        if (m_rstart_rq !== 1'b0) begin n_fail++; $display("FAIL rd_held: got %b want 0", m_rstart_rq); end
        m_finish_wresp = 1; #1;
        n_checks++;
        if (dc_finish_wresp !== 1'b1 || uart_finish_wresp !== 1'b0) begin
            n_fail++; $display("FAIL wr_fin_dc: got dc %b uart %b want 1 0", dc_finish_wresp, uart_finish_wresp);
        end
        tick();
        m_finish_wresp = 0;
        tick(); tick(); #1;
        n_checks++;
        if (m_rstart_rq !== 1'b1 || m_rin_addr !== 32'h500 || m_wstart_rq !== 1'b0) begin
            n_fail++; $display("FAIL rd_after_wr: got r %b addr %h w %b want 1 500 0", m_rstart_rq, m_rin_addr, m_wstart_rq);
        end
        tick();
        m_finish_mrd = 1;
        tick();
        m_finish_mrd = 0;
    endtask

    task automatic test_drop();
        apply_reset();
        uart_wstart_rq = 1; uart_win_addr = 32'h600; uart_in_wdata = {16{8'h11}}; uart_in_mask = 16'h0003;
        tick();
        uart_win_addr = 32'h700; uart_in_wdata = {16{8'h22}}; uart_in_mask = 16'hFFFF;
        tick();
        idle_inputs(); #1;
        n_checks++;
        if (arb_err !== 1'b1) begin n_fail++; $display("FAIL drop_err: got %b want 1", arb_err); end
        tick(); #1;
        n_checks++;
        if (m_wstart_rq !== 1'b1 || m_win_addr !== 32'h600 || m_in_wdata !== {16{8'h11}} || m_in_mask !== 16'h0003) begin
            n_fail++; $display("FAIL drop_first_kept: got %b %h %h want 1 600 0003", m_wstart_rq, m_win_addr, m_in_mask);
        end
        tick();
        m_finish_wresp = 1;
        tick();
        m_finish_wresp = 0;
        tick(); tick(); tick(); #1;
        n_checks++;
        if (m_wstart_rq !== 1'b0 || m_win_addr !== 32'h600) begin
            n_fail++; $display("FAIL drop_no_reissue: got %b %h want 0 600", m_wstart_rq, m_win_addr);
        end
        n_checks++;
        if (arb_err !== 1'b1) begin n_fail++; $display("FAIL drop_sticky: got %b want 1", arb_err); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        uart_rstart_rq = 1; uart_rin_addr = 32'h800;
        tick();
        idle_inputs();
        tick(); tick(); #1;
        n_checks++;
        if (m_rstart_rq !== 1'b1 || m_rin_addr !== 32'h800) begin
            n_fail++; $display("FAIL mid_issue: got %b %h want 1 800", m_rstart_rq, m_rin_addr);
        end
        tick();
        rst_n = 1'b0; #1;
        n_checks++;
        if (m_rstart_rq !== 1'b0 || m_rin_addr !== '0 || arb_err !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_out: got %b %h %b want 0 0 0", m_rstart_rq, m_rin_addr, arb_err);
        end
        tick();
        rst_n = 1'b1;
        tick();
        m_finish_mrd = 1; m_rdat_m_valid = 1; #1;
        n_checks++;
        if ({uart_finish_mrd, dc_finish_mrd, uart_rdat_m_valid, dc_rdat_m_valid} !== 4'b0) begin
            n_fail++; $display("FAIL mid_stray: got %b want 0000", {uart_finish_mrd, dc_finish_mrd, uart_rdat_m_valid, dc_rdat_m_valid});
        end
        tick();
        idle_inputs();
        tick(); tick(); tick(); #1;
        n_checks++;
        if (m_rstart_rq !== 1'b0 || m_wstart_rq !== 1'b0) begin
            n_fail++; $display("FAIL mid_slots_empty: got r %b w %b want 0 0", m_rstart_rq, m_wstart_rq);
        end
    endtask

`ifdef LRA_WDT_EN
    task automatic test_wdt();
        apply_reset();
        dc_rstart_rq = 1; dc_rin_addr = 32'h900;
        tick();
        idle_inputs();
        tick(); tick();
        // now in the first WAIT_R cycle
        for (int i = 0; i < 15; i++) tick();
        #1;
        n_checks++;
        if (dc_finish_mrd !== 1'b0) begin n_fail++; $display("FAIL wdt_early: got %b want 0", dc_finish_mrd); end
        tick(); #1;
        n_checks++;
        if (dc_finish_mrd !== 1'b1 || uart_finish_mrd !== 1'b0 || dc_rdat_m_valid !== 1'b0) begin
            n_fail++; $display("FAIL wdt_fire: got fin %b ufin %b vld %b want 1 0 0", dc_finish_mrd, uart_finish_mrd, dc_rdat_m_valid);
        end
        tick(); #1;
        n_checks++;
        if (arb_err !== 1'b1 || dc_finish_mrd !== 1'b0) begin
            n_fail++; $display("FAIL wdt_err: got err %b fin %b want 1 0", arb_err, dc_finish_mrd);
        end
        m_finish_mrd = 1; #1;
        n_checks++;
        if (dc_finish_mrd !== 1'b0) begin n_fail++; $display("FAIL wdt_stray: got %b want 0", dc_finish_mrd); end
        tick();
        m_finish_mrd = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_write_basic();
        test_read_rr();
        test_w_before_r();
        test_drop();
        test_reset_mid();
`ifdef LRA_WDT_EN
        test_wdt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, want completion");
        $fatal(1, "timeout");
    end
endmodule
